// File: rtl/log_offset_lut_arbiter.sv
// Round-robin arbiter sharing one registered log-offset LUT between NUM_REQ lanes.
// Tracks each grant through a 2-stage pipeline and returns the LUT result tagged to its lane.
module log_offset_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 5,
  parameter int DATA_W  = 40,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         lut_idx,
  input  logic [DATA_W-1:0]        lut_data,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [IDX_W-1:0] lut_idx_reg;
  logic             s1_vld_reg;
  logic [ID_W-1:0]  s1_id_reg;
  logic             s2_vld_reg;
  logic [ID_W-1:0]  s2_id_reg;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    cand;
  logic [IDX_W-1:0] grant_idx;

  // Search from rr_ptr, wrapping modulo NUM_REQ (which need not be a power of two).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (!rst && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) begin
          cand = cand - (ID_W+1)'(NUM_REQ);
        end
        if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = cand[ID_W-1:0];
        end
      end
    end
  end

  assign grant_idx   = req_idx[int'(grant_id)*IDX_W +: IDX_W];
  assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      lut_idx_reg <= '0;
      s1_vld_reg  <= 1'b0;
      s1_id_reg   <= '0;
      s2_vld_reg  <= 1'b0;
      s2_id_reg   <= '0;
    end else begin
      s2_vld_reg <= s1_vld_reg;
      s2_id_reg  <= s1_id_reg;
      if (grant_vld) begin
        rr_ptr_reg  <= rr_ptr_next;
        lut_idx_reg <= grant_idx;
        s1_vld_reg  <= 1'b1;
        s1_id_reg   <= grant_id;
      end else begin
        s1_vld_reg  <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_ready[gi] = grant_vld && (grant_id == ID_W'(gi));
      // Responses are suppressed during the reset cycle itself, not just after it.
      assign rsp_valid[gi] = !rst && s2_vld_reg && (s2_id_reg == ID_W'(gi));
    end
  endgenerate

  assign lut_idx  = lut_idx_reg;
  assign rsp_id   = s2_id_reg;
  assign rsp_data = lut_data;
  assign busy     = !rst && (s1_vld_reg || s2_vld_reg);

endmodule

// File: tb/tb_log_offset_lut_arbiter.sv
// Bench for log_offset_lut_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of grants and tagged responses.
module tb_log_offset_lut_arbiter;
  localparam int N   = 4;
  localparam int IW  = 5;
  localparam int DW  = 40;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*IW-1:0] req_idx = '0;
  logic [N-1:0]  req_ready;
  logic [IW-1:0] lut_idx;
  logic [DW-1:0] lut_data;
  logic [N-1:0]  rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [DW-1:0] rsp_data;
  logic          busy;

  log_offset_lut_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .lut_idx(lut_idx), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered LUT stand-in with random contents.
  logic [DW-1:0] lut_mem [32];
  always @(posedge clk) lut_data <= lut_mem[lut_idx];

  typedef struct { int due; int id; int idx; } rsp_t;
  rsp_t q[$];
  int cyc = 0, ptr = 0, exp_lut = 0, exp_g = -1;
  bit started = 0;
  int checks = 0, errors = 0;
  bit pend [N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int lane_idx(int l);
    return int'(req_idx[l*IW +: IW]);
  endfunction

  task automatic set_lane(int l, bit v, int idx);
    req_valid[l] = v;
    req_idx[l*IW +: IW] = idx[IW-1:0];
  endtask

  task automatic at_neg();
    int ev, ei;
    bit eb;
    @(negedge clk);
    exp_g = -1;
    if (!rst && !stall) begin
      for (int k = 0; k < N; k++) begin
        if (exp_g < 0 && req_valid[(ptr + k) % N]) exp_g = (ptr + k) % N;
      end
    end
    if (started) begin
      ev = -1; ei = 0; eb = 0;
      if (!rst) begin
        foreach (q[i]) begin
          if (q[i].due == cyc) begin ev = q[i].id; ei = q[i].idx; end
          if (q[i].due == cyc || q[i].due == cyc + 1) eb = 1;
        end
      end
      chk("req_ready", 64'(req_ready), (exp_g < 0) ? 64'd0 : (64'd1 << exp_g));
      chk("lut_idx", 64'(lut_idx), 64'(exp_lut));
      chk("busy", 64'(busy), 64'(eb));
      chk("rsp_valid", 64'(rsp_valid), (ev < 0) ? 64'd0 : (64'd1 << ev));
      if (ev >= 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(ev));
        chk("rsp_data", 64'(rsp_data), 64'(lut_mem[ei]));
      end
    end
  endtask

  task automatic end_cycle();
    if (rst) begin
      q.delete();
      ptr = 0;
      exp_lut = 0;
      started = 1;
    end else if (exp_g >= 0) begin
      q.push_back('{cyc + 2, exp_g, lane_idx(exp_g)});
      ptr = (exp_g + 1) % N;
      exp_lut = lane_idx(exp_g);
    end
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    end_cycle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut_mem[i] = {8'($urandom), $urandom};
    for (int l = 0; l < N; l++) set_lane(l, 1, l + 8);

    // Reset with everything requesting
    rst = 1;
    tick();
    at_neg();
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_lut_idx", 64'(lut_idx), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    end_cycle();
    rst = 0;
    at_neg();
    chk("first_grant", 64'(req_ready), 64'h1);
    end_cycle();
    req_valid = '0;
    tick(); tick();

    // Single request: lane 2, idx 3
    set_lane(2, 1, 3);
    at_neg(); chk("single_ready", 64'(req_ready), 64'h4); end_cycle();
    set_lane(2, 0, 0);
    at_neg(); chk("single_lut_idx", 64'(lut_idx), 64'd3); end_cycle();
    at_neg();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("single_rsp_id", 64'(rsp_id), 64'd2);
    chk("single_rsp_data", 64'(rsp_data), 64'(lut_mem[3]));
    end_cycle();

    // Round-robin with all lanes requesting continuously; pointer starts at 3
    for (int l = 0; l < N; l++) set_lane(l, 1, l + 8);
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("rr_grant", 64'(req_ready), 64'd1 << ((3 + k) % N));
      if (k >= 2) begin
        chk("rr_rsp_id", 64'(rsp_id), 64'((3 + k - 2) % N));
        chk("rr_rsp_data", 64'(rsp_data), 64'(lut_mem[8 + (3 + k - 2) % N]));
      end
      end_cycle();
    end
    req_valid = '0;
    tick(); tick();

    // Pointer wrap: lane 2, then lanes 3 and 1
    set_lane(2, 1, 17);
    at_neg(); chk("wrap_lane2", 64'(req_ready), 64'h4); end_cycle();
    set_lane(2, 0, 0); set_lane(3, 1, 30); set_lane(1, 1, 1);
    at_neg(); chk("wrap_lane3", 64'(req_ready), 64'h8); end_cycle();
    set_lane(3, 0, 0);
    at_neg(); chk("wrap_lane1", 64'(req_ready), 64'h2); end_cycle();
    set_lane(1, 0, 0);
    for (int l = 0; l < N; l++) set_lane(l, 1, 31 - l);
    at_neg(); chk("wrap_resume", 64'(req_ready), 64'h4); end_cycle();
    req_valid = '0;
    tick(); tick();

    // Stall with one lookup in flight (pointer at 3 -> lane 3 leaves it at 0)
    set_lane(3, 1, 12);
    at_neg(); chk("stall_pre", 64'(req_ready), 64'h8); end_cycle();
    set_lane(3, 0, 0); set_lane(0, 1, 5); set_lane(1, 1, 6);
    stall = 1;
    at_neg(); chk("stall_ready0", 64'(req_ready), 64'd0); chk("stall_busy0", 64'(busy), 64'd1); end_cycle();
    at_neg(); chk("stall_ready1", 64'(req_ready), 64'd0); chk("stall_rsp", 64'(rsp_valid), 64'h8); end_cycle();
    at_neg(); chk("stall_ready2", 64'(req_ready), 64'd0); chk("stall_busy2", 64'(busy), 64'd0); end_cycle();
    stall = 0;
    at_neg(); chk("stall_release", 64'(req_ready), 64'h1); end_cycle();
    set_lane(0, 0, 0);
    tick();
    set_lane(1, 0, 0);
    tick(); tick();

    // Reset mid-flight
    set_lane(1, 1, 9);
    at_neg(); chk("midrst_grant", 64'(req_ready), 64'h2); end_cycle();
    set_lane(1, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    for (int l = 0; l < N; l++) set_lane(l, 1, l);
    at_neg();
    chk("midrst_rsp", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ptr", 64'(req_ready), 64'h1);
    end_cycle();
    req_valid = '0;
    tick(); tick();

    // Random traffic
    for (int l = 0; l < N; l++) pend[l] = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom % 8 == 0);
      rst = ($urandom % 100 == 0);
      for (int l = 0; l < N; l++) begin
        if (!pend[l] && ($urandom % 2 == 1)) begin
          pend[l] = 1;
          set_lane(l, 1, int'($urandom % 32));
        end
      end
      at_neg();
      end_cycle();
      if (exp_g >= 0) begin
        pend[exp_g] = 0;
        req_valid[exp_g] = 1'b0;
      end
    end
    rst = 0; stall = 0; req_valid = '0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/log_offset_lut_arbiter.md
Name: log_offset_lut_arbiter

Overview:
Shares one registered log-offset LUT (5-bit shift_offset in, 40-bit log_offset out, 1-cycle latency) between NUM_REQ requester lanes of the 16b fractional PE array. Each cycle it grants one requester by round-robin and drives that requester's index to the LUT. It tracks the grant through a 2-stage pipeline and returns the LUT result tagged to the granted lane. Throughput is one lookup per cycle. The block sits between the PE lanes and the single LUT instance.

Parameters:
NUM_REQ, 4, number of requester lanes (2..8)
IDX_W, 5, LUT index width (shift_offset)
DATA_W, 40, LUT data width (log_offset)
ID_W, $clog2(NUM_REQ), requester id width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  when 1, no new grants are issued; in-flight lookups still complete
req_valid  input  NUM_REQ  per-lane lookup request
req_idx  input  NUM_REQ*IDX_W  per-lane index; lane i uses bits [i*IDX_W +: IDX_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
lut_idx  output  IDX_W  registered index to the LUT shift_offset input
lut_data  input  DATA_W  LUT log_offset output, valid 1 cycle after lut_idx
rsp_valid  output  NUM_REQ  one-hot response strobe, 1 cycle wide
rsp_id  output  ID_W  lane id of the current response
rsp_data  output  DATA_W  equals lut_data whenever any rsp_valid bit is 1
busy  output  1  1 while any lookup is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values: rr_ptr=0, lut_idx=0, both pipeline valid bits=0, rsp_valid=0, rsp_id=0, busy=0. req_ready is 0 while rst=1.
- Grant (combinational, cycle t):
  - If stall=0, search req_valid starting at lane rr_ptr and wrapping modulo NUM_REQ. The first set lane g gets req_ready[g]=1; all other req_ready bits are 0.
  - A handshake completes when req_valid[g]=1 and req_ready[g]=1.
  - A requester holds req_valid and req_idx stable until it is granted.
- Pointer: on a handshake, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Stage 1 (end of t): on a handshake, lut_idx <= req_idx[g], s1_vld <= 1, s1_id <= g. With no handshake, lut_idx holds its last value (no toggling) and s1_vld <= 0.
- Stage 2 (end of t+1): s2_vld <= s1_vld, s2_id <= s1_id. The LUT registers lut_data in the same edge.
- Response (cycle t+2):
  - rsp_valid = s2_vld ? onehot(s2_id) : 0.
  - rsp_id = s2_id.
  - rsp_data = lut_data, passed through combinationally.
  - Handshake-to-response latency is exactly 2 cycles.
- No response backpressure: lanes must accept rsp_valid in the cycle it is asserted.
- busy = s1_vld | s2_vld.
- Back-to-back: grants in consecutive cycles produce responses in consecutive cycles, in grant order.
- A lane may be granted again while its earlier lookup is still in flight.
- Stall: stall=1 forces req_ready=0 and freezes rr_ptr. Stages 1 and 2 keep draining, so busy falls within 2 cycles.
- Reset mid-operation: all in-flight lookups are dropped. rsp_valid is 0 in the reset cycle and every cycle after it until a new handshake +2 cycles.
- Index values: all 2^IDX_W values are passed unmodified. The arbiter does not interpret the index.
- Single-lane case: a lane that is the only requester is granted every cycle.

Test Plan:
- Reset check: assert rst for 2 cycles with all req_valid=1. Required: req_ready=0, rsp_valid=0, lut_idx=0, busy=0. After release, lane 0 is granted first.
- Single request: lane 2 with idx=5'd3, other lanes idle. Required: req_ready=4'b0100 at t; lut_idx=3 at t+1; rsp_valid=4'b0100, rsp_id=2, rsp_data=LUT[3] at t+2.
- Round-robin fairness: all 4 lanes request continuously with idx=lane+8. Required: grant order 0,1,2,3,0,… with one grant per cycle. Responses follow 2 cycles behind with idx 8,9,10,11 in matching order.
- Pointer wrap: lanes 3 and 1 request after a lane-2 grant. Required: lane 3 is granted, then lane 1, then the pointer resumes at 2.
- Stall: stall=1 for 3 cycles while lanes 0 and 1 request and one lookup is in flight. Required: req_ready=0 for those 3 cycles. The in-flight response still appears and busy drops. Lane 0 is granted in the first cycle after stall deasserts.
- Reset mid-flight: grant lane 1 at t, then rst=1 at t+1. Required: no rsp_valid at t+2, busy=0 after reset, rr_ptr=0.
